// File: rtl/m2s_access_queue.sv
// In-order issue / in-order retire request queue feeding the Multi2Sim bridge.
// Completions may arrive in any order and are matched to entries by tag.

package m2s_aq_pkg;
    typedef enum logic [1:0] {E_FREE, E_QUEUED, E_ISSUED, E_DONE} entry_st_t;
endpackage

module m2s_aq_entry #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          acc,
    input  logic                          iss,
    input  logic                          cmp,
    input  logic                          ret,
    input  logic                          set_write,
    input  logic [ADDR_W-1:0]             set_addr,
    input  logic [DATA_W-1:0]             set_data,
    input  logic [DATA_W-1:0]             cmp_data,
    output m2s_aq_pkg::entry_st_t         st,
    output logic                          write,
    output logic [ADDR_W-1:0]             addr,
    output logic [DATA_W-1:0]             data
);
    import m2s_aq_pkg::*;

    entry_st_t st_nxt;

    // Each event is only ever raised for an entry in the matching source state.
    always_comb begin
        st_nxt = st;
        case (st)
            E_FREE:   if (acc) st_nxt = E_QUEUED;
            E_QUEUED: if (iss) st_nxt = E_ISSUED;
            E_ISSUED: if (cmp) st_nxt = E_DONE;
            E_DONE:   if (ret) st_nxt = E_FREE;
            default:  st_nxt = E_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= E_FREE;
            write <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else begin
            st <= st_nxt;
            if (acc) begin
                write <= set_write;
                addr  <= set_addr;
                data  <= set_data;
            end else if (cmp) begin
                data <= cmp_data;
            end
        end
    end
endmodule

module m2s_access_queue #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic              iss_write,
    output logic [ADDR_W-1:0] iss_addr,
    output logic [DATA_W-1:0] iss_data,
    output logic [TAG_W-1:0]  iss_tag,
    input  logic              cmp_valid,
    input  logic [TAG_W-1:0]  cmp_tag,
    input  logic [DATA_W-1:0] cmp_data,
    output logic              cmp_err,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W:0]    outstanding
);
    import m2s_aq_pkg::*;

    logic [DEPTH-1:0][1:0]        st;
    logic [DEPTH-1:0]             wr;
    logic [DEPTH-1:0][ADDR_W-1:0] ad;
    logic [DEPTH-1:0][DATA_W-1:0] dt;
    logic [TAG_W-1:0]             alloc_ptr, iss_ptr, ret_ptr;
    logic                         acc, iss, cmp_ok, ret;

    // A retire in the same cycle cannot free the alloc slot early: ready looks
    // only at registered entry state.
    assign req_ready = !rst && (st[alloc_ptr] == E_FREE);
    assign iss_valid = !rst && (st[iss_ptr] == E_QUEUED);
    assign rsp_valid = !rst && (st[ret_ptr] == E_DONE);

    assign acc    = req_valid && req_ready;
    assign iss    = iss_valid && iss_ready;
    assign ret    = rsp_valid && rsp_ready;
    assign cmp_ok = cmp_valid && (st[cmp_tag] == E_ISSUED);

    assign iss_write = wr[iss_ptr];
    assign iss_addr  = ad[iss_ptr];
    assign iss_data  = dt[iss_ptr];
    assign iss_tag   = iss_ptr;
    assign rsp_write = wr[ret_ptr];
    assign rsp_data  = dt[ret_ptr];

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        m2s_aq_entry #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ent (
            .clk       (clk),
            .rst       (rst),
            .acc       (acc    && (alloc_ptr == TAG_W'(i))),
            .iss       (iss    && (iss_ptr   == TAG_W'(i))),
            .cmp       (cmp_ok && (cmp_tag   == TAG_W'(i))),
            .ret       (ret    && (ret_ptr   == TAG_W'(i))),
            .set_write (req_write),
            .set_addr  (req_addr),
            .set_data  (req_data),
            .cmp_data  (cmp_data),
            .st        (st[i]),
            .write     (wr[i]),
            .addr      (ad[i]),
            .data      (dt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr   <= '0;
            iss_ptr     <= '0;
            ret_ptr     <= '0;
            outstanding <= '0;
            cmp_err     <= 1'b0;
        end else begin
            if (acc) alloc_ptr <= alloc_ptr + 1'b1;
            if (iss) iss_ptr   <= iss_ptr + 1'b1;
            if (ret) ret_ptr   <= ret_ptr + 1'b1;
            cmp_err <= cmp_valid && !cmp_ok;
            case ({acc, ret})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end
endmodule

// File: tb/tb_m2s_access_queue.sv
// Directed scenarios plus a randomized run against a transaction-queue model.
module tb_m2s_access_queue;
    localparam int ADDR_W = 32, DATA_W = 8, DEPTH = 4, TAG_W = 2;

    logic clk = 1'b0;
    logic rst, req_valid, req_ready, req_write, iss_valid, iss_ready, iss_write;
    logic cmp_valid, cmp_err, rsp_valid, rsp_ready, rsp_write;
    logic [ADDR_W-1:0] req_addr, iss_addr;
    logic [DATA_W-1:0] req_data, iss_data, cmp_data, rsp_data;
    logic [TAG_W-1:0]  iss_tag, cmp_tag;
    logic [TAG_W:0]    outstanding;

    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    m2s_access_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_write(iss_write),
        .iss_addr(iss_addr), .iss_data(iss_data), .iss_tag(iss_tag),
        .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_data(cmp_data), .cmp_err(cmp_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_data(rsp_data), .outstanding(outstanding)
    );

    // Reference: list of live transactions in request order; tag = head + position.
    typedef struct {
        bit           w;
        bit [31:0]    a;
        bit [7:0]     d;
        bit           issued;
        bit           done;
        bit [7:0]     cd;
    } txn_t;
    txn_t q[$];
    int   head;
    bit   exp_err;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        req_valid = 0; req_write = 0; req_addr = '0; req_data = '0;
        iss_ready = 0; cmp_valid = 0; cmp_tag = '0; cmp_data = '0; rsp_ready = 0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); rst = 0; #1;
    endtask

    task automatic test_reset();
        idle(); rst = 1; tick(); tick();
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready_in_rst: got %b want 0", req_ready); end
        n_vec++; if (iss_valid !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valids: got iss %b rsp %b want 0 0", iss_valid, rsp_valid); end
        n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        n_vec++; if (cmp_err !== 1'b0) begin n_err++; $display("FAIL reset_cmp_err: got %b want 0", cmp_err); end
        rst = 0; #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready_after: got %b want 1", req_ready); end
    endtask

    task automatic test_single_write();
        do_reset();
        req_valid = 1; req_write = 1; req_addr = 32'h10; req_data = 8'hAA; iss_ready = 1;
        tick(); req_valid = 0;
        n_vec++; if (iss_valid !== 1'b1 || iss_tag !== 2'd0 || iss_data !== 8'hAA || iss_write !== 1'b1 || iss_addr !== 32'h10)
            begin n_err++; $display("FAIL single_issue: got v%b tag%0d d%h w%b a%h want v1 tag0 dAA w1 a10", iss_valid, iss_tag, iss_data, iss_write, iss_addr); end
        tick();
        n_vec++; if (iss_valid !== 1'b0 || outstanding !== 3'd1) begin n_err++; $display("FAIL single_issued: got iss_valid %b out %0d want 0 1", iss_valid, outstanding); end
        cmp_valid = 1; cmp_tag = 0; cmp_data = 8'h5C; #1;
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_no_bypass: got rsp_valid %b want 0", rsp_valid); end
        tick(); cmp_valid = 0;
        n_vec++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || cmp_err !== 1'b0) begin n_err++; $display("FAIL single_rsp: got v%b w%b err%b want 1 1 0", rsp_valid, rsp_write, cmp_err); end
        rsp_ready = 1; tick(); rsp_ready = 0;
        n_vec++; if (outstanding !== 3'd0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_retire: got out %0d rsp_valid %b want 0 0", outstanding, rsp_valid); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req_valid = 1; req_write = 0; req_addr = 32'(i); req_data = 8'(i + 1);
            n_vec++; if (req_ready !== (i < 4)) begin n_err++; $display("FAIL fill_ready_%0d: got %b want %b", i, req_ready, (i < 4)); end
            tick();
        end
        req_valid = 0;
        n_vec++; if (outstanding !== 3'd4 || req_ready !== 1'b0) begin n_err++; $display("FAIL fill_full: got out %0d ready %b want 4 0", outstanding, req_ready); end
        iss_ready = 1;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (iss_valid !== 1'b1 || iss_tag !== 2'(i) || iss_data !== 8'(i + 1))
                begin n_err++; $display("FAIL fill_issue_%0d: got v%b tag%0d d%h want v1 tag%0d d%h", i, iss_valid, iss_tag, iss_data, i, 8'(i + 1)); end
            tick();
        end
        n_vec++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL fill_drained: got iss_valid %b want 0", iss_valid); end
        iss_ready = 0;
    endtask

    task automatic test_out_of_order();
        logic [1:0] ctag [4];
        logic [7:0] cdat [4];
        ctag = '{2'd2, 2'd0, 2'd3, 2'd1};
        cdat = '{8'h22, 8'h00, 8'h33, 8'h11};
        do_reset();
        iss_ready = 1; req_write = 0;
        for (int i = 0; i < 4; i++) begin req_valid = 1; req_addr = 32'h100 + 32'(i); req_data = 8'hF0; tick(); end
        req_valid = 0; tick(); tick(); iss_ready = 0;
        n_vec++; if (iss_valid !== 1'b0 || outstanding !== 3'd4) begin n_err++; $display("FAIL ooo_issued: got iss_valid %b out %0d want 0 4", iss_valid, outstanding); end
        for (int i = 0; i < 4; i++) begin
            cmp_valid = 1; cmp_tag = ctag[i]; cmp_data = cdat[i];
            tick();
            if (i == 0) begin
                n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL ooo_early_rsp: got %b want 0", rsp_valid); end
            end
            if (i == 1) begin
                n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h00) begin n_err++; $display("FAIL ooo_first_rsp: got v%b d%h want v1 d00", rsp_valid, rsp_data); end
            end
        end
        cmp_valid = 0; rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 8'(i * 8'h11)) begin n_err++; $display("FAIL ooo_rsp_%0d: got v%b d%h want v1 d%h", i, rsp_valid, rsp_data, 8'(i * 8'h11)); end
            tick();
        end
        rsp_ready = 0;
        n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL ooo_empty: got out %0d want 0", outstanding); end
    endtask

    task automatic test_bogus_completion();
        do_reset();
        req_valid = 1; req_write = 0; iss_ready = 1; tick();
        req_valid = 0; tick(); iss_ready = 0;
        cmp_valid = 1; cmp_tag = 0; cmp_data = 8'h5A; tick();
        cmp_tag = 1; cmp_data = 8'hEE; tick(); cmp_valid = 0;
        n_vec++; if (cmp_err !== 1'b1 || outstanding !== 3'd1 || rsp_data !== 8'h5A) begin n_err++; $display("FAIL bogus_free: got err%b out%0d d%h want 1 1 5A", cmp_err, outstanding, rsp_data); end
        tick();
        n_vec++; if (cmp_err !== 1'b0) begin n_err++; $display("FAIL bogus_pulse: got %b want 0", cmp_err); end
        cmp_valid = 1; cmp_tag = 0; cmp_data = 8'hEE; tick(); cmp_valid = 0;
        n_vec++; if (cmp_err !== 1'b1 || rsp_data !== 8'h5A || rsp_valid !== 1'b1) begin n_err++; $display("FAIL bogus_dup: got err%b d%h v%b want 1 5A 1", cmp_err, rsp_data, rsp_valid); end
        tick();
        n_vec++; if (cmp_err !== 1'b0 || outstanding !== 3'd1) begin n_err++; $display("FAIL bogus_dup_pulse: got err%b out%0d want 0 1", cmp_err, outstanding); end
    endtask

    task automatic test_full_retire();
        do_reset();
        iss_ready = 1; req_write = 0;
        for (int i = 0; i < 4; i++) begin req_valid = 1; req_data = 8'(i); tick(); end
        req_valid = 0; tick(); tick(); iss_ready = 0;
        cmp_valid = 1; cmp_tag = 0; cmp_data = 8'h77; tick(); cmp_valid = 0;
        req_valid = 1; req_write = 1; req_addr = 32'h55; req_data = 8'h99; rsp_ready = 1; #1;
        n_vec++; if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin n_err++; $display("FAIL full_retire_ready: got ready %b rsp_valid %b want 0 1", req_ready, rsp_valid); end
        tick(); rsp_ready = 0;
        n_vec++; if (req_ready !== 1'b1 || outstanding !== 3'd3) begin n_err++; $display("FAIL full_retire_next: got ready %b out %0d want 1 3", req_ready, outstanding); end
        tick(); req_valid = 0;
        n_vec++; if (outstanding !== 3'd4 || iss_valid !== 1'b1 || iss_tag !== 2'd0 || iss_data !== 8'h99 || iss_write !== 1'b1)
            begin n_err++; $display("FAIL full_retire_refill: got out%0d v%b tag%0d d%h w%b want 4 1 0 99 1", outstanding, iss_valid, iss_tag, iss_data, iss_write); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_write = 0; iss_ready = 1;
        for (int i = 0; i < 3; i++) begin req_valid = 1; req_data = 8'(i); tick(); end
        req_valid = 0; iss_ready = 0; #1;
        n_vec++; if (outstanding !== 3'd3 || iss_valid !== 1'b1 || iss_tag !== 2'd2) begin n_err++; $display("FAIL mid_setup: got out%0d v%b tag%0d want 3 1 2", outstanding, iss_valid, iss_tag); end
        rst = 1; #1;
        n_vec++; if (iss_valid !== 1'b0 || req_ready !== 1'b0) begin n_err++; $display("FAIL mid_forced: got iss_valid %b req_ready %b want 0 0", iss_valid, req_ready); end
        tick(); rst = 0; #1;
        n_vec++; if (outstanding !== 3'd0 || iss_valid !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1)
            begin n_err++; $display("FAIL mid_after: got out%0d iv%b rv%b rr%b want 0 0 0 1", outstanding, iss_valid, rsp_valid, req_ready); end
        cmp_valid = 1; cmp_tag = 0; cmp_data = 8'h01; tick(); cmp_valid = 0;
        n_vec++; if (cmp_err !== 1'b1) begin n_err++; $display("FAIL mid_late_cmp: got %b want 1", cmp_err); end
    endtask

    task automatic test_random();
        int  n_iss, k;
        bit  e_rr, e_iv, e_rv, ok, acc_h, ret_h;
        txn_t t;
        do_reset();
        q.delete(); head = 0; exp_err = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst       = ($urandom_range(199) == 0);
            req_valid = $urandom_range(1);
            req_write = $urandom_range(1);
            req_addr  = $urandom;
            req_data  = 8'($urandom);
            iss_ready = ($urandom_range(3) != 0);
            rsp_ready = ($urandom_range(2) != 0);
            cmp_valid = ($urandom_range(1) == 1);
            cmp_data  = 8'($urandom);
            cmp_tag   = 2'($urandom);
            if ($urandom_range(3) != 0)
                foreach (q[j]) if (q[j].issued && !q[j].done && $urandom_range(1) == 1) cmp_tag = 2'((head + j) % DEPTH);
            #1;
            n_iss = 0;
            foreach (q[j]) if (q[j].issued) n_iss++;
            e_rr = !rst && (q.size() < DEPTH);
            e_iv = !rst && (n_iss < q.size());
            e_rv = !rst && (q.size() > 0) && q[0].done;

            n_vec++; if (req_ready !== e_rr) begin n_err++; $display("FAIL rnd_req_ready c%0d: got %b want %b", cyc, req_ready, e_rr); end
            n_vec++; if (iss_valid !== e_iv) begin n_err++; $display("FAIL rnd_iss_valid c%0d: got %b want %b", cyc, iss_valid, e_iv); end
            if (e_iv) begin
                n_vec++; if (iss_tag !== 2'((head + n_iss) % DEPTH) || iss_write !== q[n_iss].w || iss_addr !== q[n_iss].a || iss_data !== q[n_iss].d)
                    begin n_err++; $display("FAIL rnd_iss_fields c%0d: got tag%0d w%b a%h d%h want tag%0d w%b a%h d%h", cyc, iss_tag, iss_write, iss_addr, iss_data,
                                            (head + n_iss) % DEPTH, q[n_iss].w, q[n_iss].a, q[n_iss].d); end
            end
            n_vec++; if (rsp_valid !== e_rv) begin n_err++; $display("FAIL rnd_rsp_valid c%0d: got %b want %b", cyc, rsp_valid, e_rv); end
            if (e_rv) begin
                n_vec++; if (rsp_write !== q[0].w || rsp_data !== q[0].cd) begin n_err++; $display("FAIL rnd_rsp_fields c%0d: got w%b d%h want w%b d%h", cyc, rsp_write, rsp_data, q[0].w, q[0].cd); end
            end
            n_vec++; if (outstanding !== 3'(q.size())) begin n_err++; $display("FAIL rnd_outstanding c%0d: got %0d want %0d", cyc, outstanding, q.size()); end
            n_vec++; if (cmp_err !== exp_err) begin n_err++; $display("FAIL rnd_cmp_err c%0d: got %b want %b", cyc, cmp_err, exp_err); end

            if (rst) begin
                q.delete(); head = 0; exp_err = 0;
            end else begin
                k  = (int'(cmp_tag) - head + DEPTH) % DEPTH;
                ok = (k < q.size()) && q[k].issued && !q[k].done;
                exp_err = cmp_valid && !ok;
                acc_h = req_valid && e_rr;
                ret_h = rsp_ready && e_rv;
                if (cmp_valid && ok) begin t = q[k]; t.done = 1; t.cd = cmp_data; q[k] = t; end
                if (e_iv && iss_ready) begin t = q[n_iss]; t.issued = 1; q[n_iss] = t; end
                if (ret_h) begin void'(q.pop_front()); head = (head + 1) % DEPTH; end
                if (acc_h) begin
                    t.w = req_write; t.a = req_addr; t.d = req_data; t.issued = 0; t.done = 0; t.cd = 8'h00;
                    q.push_back(t);
                end
            end
            tick();
        end
        rst = 0;
    endtask

    initial begin
        idle(); rst = 1;
        test_reset();
        test_single_write();
        test_fill();
        test_out_of_order();
        test_bogus_completion();
        test_full_retire();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/m2s_access_queue.md
# m2s_access_queue

Synthesizable request buffer and reorder stage that sits directly upstream of the Multi2Sim co-simulation bridge. It collects memory access requests from RTL masters, assigns each one a tag, and issues them in order to the bridge, which performs the `$m2s_access` call. It then accepts completions, which may arrive out of order on any `$m2s_step` boundary, and returns responses to the master strictly in request order.

## Interface

Parameters:
- `ADDR_W`, 32, access address width.
- `DATA_W`, 8, access data width.
- `DEPTH`, 4, number of entries; power of two, at least 2.
- `TAG_W`, `$clog2(DEPTH)`, tag width (derived).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  master offers a request.
- `req_ready`  out  1  queue can accept; combinational from registered state only.
- `req_write`  in  1  access type: 1 = write, 0 = read.
- `req_addr`  in  `ADDR_W`  access address.
- `req_data`  in  `DATA_W`  write data; ignored for reads.
- `iss_valid`  out  1  an issue is pending toward the bridge.
- `iss_ready`  in  1  bridge accepts the issue.
- `iss_write`  out  1  type of the issued entry.
- `iss_addr`  out  `ADDR_W`  address of the issued entry.
- `iss_data`  out  `DATA_W`  data of the issued entry.
- `iss_tag`  out  `TAG_W`  tag of the issued entry; equals its entry index.
- `cmp_valid`  in  1  bridge reports a completion.
- `cmp_tag`  in  `TAG_W`  tag being completed.
- `cmp_data`  in  `DATA_W`  read data; for writes it is stored but not meaningful.
- `cmp_err`  out  1  one-cycle pulse when a completion targets a non-ISSUED entry.
- `rsp_valid`  out  1  in-order response available.
- `rsp_ready`  in  1  master consumes the response.
- `rsp_write`  out  1  type of the responding entry.
- `rsp_data`  out  `DATA_W`  completion data of the responding entry.
- `outstanding`  out  `TAG_W+1`  number of non-FREE entries.

## Operation

- The queue is a ring of `DEPTH` entries. Each entry holds {state, write, addr, data}.
- Entry states: FREE → QUEUED (request accepted) → ISSUED (issue handshake) → DONE (completion) → FREE (response handshake).
- Three pointers, each `TAG_W` bits wide and wrapping modulo `DEPTH`:
  - `alloc_ptr` points at the next entry to allocate.
  - `iss_ptr` points at the next entry to issue.
  - `ret_ptr` points at the next entry to respond.
- `req_ready` = (entry[`alloc_ptr`] == FREE). On accept, the entry becomes QUEUED and `alloc_ptr` advances.
- `iss_valid` = (entry[`iss_ptr`] == QUEUED), and the `iss_*` fields come from that entry. On handshake, the entry becomes ISSUED and `iss_ptr` advances.
- On `cmp_valid`, if entry[`cmp_tag`] == ISSUED: the entry becomes DONE and `cmp_data` is written to it.
  - Otherwise, `cmp_err` = 1 in the next cycle and no state changes.
- `rsp_valid` = (entry[`ret_ptr`] == DONE). On handshake, the entry becomes FREE and `ret_ptr` advances.
- `outstanding` increments on accept and decrements on retire. Both in the same cycle leaves it unchanged. Range is 0..`DEPTH`.
- All four events (accept, issue, complete, retire) may occur in the same cycle on different entries; each applies independently.

## Timing

- Reset (`rst` high at the edge): all entries FREE, all pointers 0, `outstanding` = 0, `cmp_err` = 0.
  - While `rst` is high, `req_ready`, `iss_valid` and `rsp_valid` are forced to 0.
  - From the first cycle after reset is deasserted, `req_ready` = 1.
- Reset mid-operation discards every entry regardless of state. Later completions for discarded tags produce `cmp_err`.
- Accept → `iss_valid`: 1 cycle minimum. There is no same-cycle bypass.
- Completion → `rsp_valid`: 1 cycle minimum, and only if the entry is at `ret_ptr`.
- Full queue (`outstanding` == `DEPTH`): `req_ready` = 0 even in a cycle where a retire occurs. It becomes 1 in the following cycle.
- A completion presented in the same cycle as the issue handshake of the same tag sees QUEUED state. It is rejected with `cmp_err`.
- Duplicate completion (entry already DONE): raises `cmp_err`; the data is not overwritten.
- `iss_*` and `rsp_*` fields hold stable while valid is high and ready is low.
- `cmp_err` is registered and is a 1-cycle pulse per offending completion.

## Test plan

- Single write: `req_write`=1, `req_addr`=0x10, `req_data`=0xAA with `iss_ready`=1.
  - Required: `iss_valid` next cycle with `iss_tag`=0 and `iss_data`=0xAA.
  - Then `cmp_tag`=0 → `rsp_valid`=1 one cycle later with `rsp_write`=1, and `outstanding` returns to 0 after the retire.
- Fill: `iss_ready`=0, 5 back-to-back requests.
  - Required: the first 4 are accepted, `req_ready`=0 with `outstanding`=4, and the 5th is held.
  - Raise `iss_ready` → tags issue in order 0,1,2,3.
- Out-of-order completion: 4 reads issued, then completed in tag order 2, 0, 3, 1 with data 0x22, 0x00, 0x33, 0x11.
  - Required: responses in the order 0x00, 0x11, 0x22, 0x33.
  - The first `rsp_valid` appears the cycle after tag 0 completes.
- Bogus completion: `cmp_tag`=1 while entry 1 is FREE, then a duplicate completion on a DONE entry.
  - Required: `cmp_err` pulses once for each.
  - No change to `outstanding` or `rsp_data`.
- Full with simultaneous retire: queue full, `rsp_ready`=1 on a DONE head while `req_valid`=1.
  - Required: `req_ready`=0 in that cycle, then 1 in the next; the request is accepted into the freed entry.
- Reset mid-operation: 2 requests ISSUED and 1 QUEUED, then `rst` for 1 cycle.
  - Required: `outstanding`=0, all valids 0, and `req_ready`=1 afterward.
  - A late `cmp_tag`=0 → `cmp_err`=1.
